lane_unpacker: RTL and testbench

Output-side counterpart to the fusion unit's sign-mask generation. It accepts one packed operand/result word per handshake, together with the per-lane sign mask for its precision. It splits the word at the mask boundaries and emits each element one per cycle, sign- or zero-extended to a full byte, over a valid/ready stream. It sits between the packed fusion datapath and the element-wise accumulate/writeback logic.

---
 rtl/lane_unpacker_if.sv | 28 ++
 rtl/lane_unpacker.sv | 134 +++++++++++++
 tb/tb_lane_unpacker.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_unpacker_if.sv
// Handshake bundle for lane_unpacker: packed-word input stream and element output stream.
interface lane_unpacker_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 2,
  parameter int unsigned OUT_W  = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*LANE_W-1:0]    in_data;
  logic [LANES-1:0]           in_signed;
  logic                       in_is_signed;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [$clog2(LANES)-1:0]   out_idx;
  logic                       out_last;
  logic                       err;

  modport master (
    output in_valid, in_data, in_signed, in_is_signed, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, err
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_is_signed, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, err
  );
endinterface

// File: rtl/lane_unpacker.sv
// Splits a packed lane word at sign-mask boundaries and streams extended elements one per cycle.
// Optional LANE_UNPACK_ERR_EN: reject words whose top mask bit is clear and pulse err.
module lane_unpacker #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 2,
  parameter int unsigned OUT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lane_unpacker_if.slave  bus
);
  localparam int unsigned DataW = LANES * LANE_W;
  localparam int unsigned IdxW  = $clog2(LANES);
  localparam logic [IdxW-1:0] TopLane = IdxW'(LANES - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_t;

  typedef struct packed {
    logic [IdxW-1:0]  e;
    logic [OUT_W-1:0] val;
  } elem_t;

  // Element starting at lane s: closes at the lowest mask bit at or above s.
  function automatic elem_t pick(input logic [DataW-1:0] d, input logic [LANES-1:0] m,
                                 input logic [IdxW-1:0] s, input logic sg);
    elem_t            r;
    logic [OUT_W-1:0] sh;
    logic             msb;
    int               w;
    r.e = TopLane;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(s))) r.e = IdxW'(i);
    end
    sh  = OUT_W'(d) >> (LANE_W * s);
    w   = int'(LANE_W) * (int'(r.e) - int'(s) + 1);
    msb = 1'b0;
    for (int b = 0; b < OUT_W; b++) begin
      if (b == w - 1) msb = sh[b];
    end
    for (int b = 0; b < OUT_W; b++) begin
      r.val[b] = (b < w) ? sh[b] : (sg & msb);
    end
    return r;
  endfunction

  state_t           state_q;
  logic [DataW-1:0] data_q;
  logic [LANES-1:0] mask_q;
  logic             sgn_q;
  logic [IdxW-1:0]  e_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [IdxW-1:0]  idx_q;
  logic             out_last_q;

  logic             accept;
  logic             advance;
  logic             bad_word;
  logic [LANES-1:0] mask_in;
  elem_t            first_elem;
  elem_t            next_elem;

  always_comb begin
`ifdef LANE_UNPACK_ERR_EN
    mask_in  = bus.in_signed;
    bad_word = ~bus.in_signed[LANES-1];
`else
    mask_in  = bus.in_signed | {1'b1, {(LANES-1){1'b0}}};
    bad_word = 1'b0;
`endif
  end

  assign bus.in_ready = rst_n &&
                        ((state_q == StIdle) || (out_valid_q && bus.out_ready && out_last_q));
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = out_valid_q && bus.out_ready;

  always_comb begin
    first_elem = pick(bus.in_data, mask_in, '0, bus.in_is_signed);
    next_elem  = pick(data_q, mask_q, e_q + 1'b1, sgn_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mask_q      <= '0;
      sgn_q       <= 1'b0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      out_last_q  <= 1'b0;
    end else if (accept && !bad_word) begin
      state_q     <= StEmit;
      data_q      <= bus.in_data;
      mask_q      <= mask_in;
      sgn_q       <= bus.in_is_signed;
      e_q         <= first_elem.e;
      out_valid_q <= 1'b1;
      out_data_q  <= first_elem.val;
      idx_q       <= '0;
      out_last_q  <= (first_elem.e == TopLane);
    end else if (accept || (advance && out_last_q)) begin
      // Rejected word or end of word with nothing new: fall back to idle.
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      e_q         <= next_elem.e;
      out_data_q  <= next_elem.val;
      idx_q       <= idx_q + 1'b1;
      out_last_q  <= (next_elem.e == TopLane);
    end
  end

`ifdef LANE_UNPACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && bad_word;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_lane_unpacker.sv
// Scoreboarded random + directed bench for lane_unpacker against an arithmetic element model.
module tb_lane_unpacker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lane_unpacker_if bus ();

  lane_unpacker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] idx;
    bit         last;
  } exp_t;

  exp_t sbq[$];
  bit   err_exp[int];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Reference: walk lanes, close an element at each boundary bit, extend arithmetically.
  function automatic void push_word(input logic [7:0] d, input logic [3:0] m, input bit sg);
    int   mm, start, idx, width, v;
    exp_t e;
`ifdef LANE_UNPACK_ERR_EN
    if (!m[3]) begin
      err_exp[cyc + 1] = 1'b1;
      return;
    end
`endif
    mm    = int'(m) | 8;
    start = 0;
    idx   = 0;
    for (int lane = 0; lane < 4; lane++) begin
      if (((mm >> lane) & 1) == 1) begin
        width = 2 * (lane - start + 1);
        v     = (int'(d) >> (2 * start)) % (1 << width);
        if (sg && v >= (1 << (width - 1))) v = v - (1 << width) + 256;
        e.d    = v[7:0];
        e.idx  = idx[1:0];
        e.last = (lane == 3);
        sbq.push_back(e);
        start = lane + 1;
        idx++;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered just after a posedge; returns just after the posedge that took the word.
  task automatic send(input logic [7:0] d, input logic [3:0] m, input bit sg);
    int n = 0;
    bus.in_valid     = 1'b1;
    bus.in_data      = d;
    bus.in_signed    = m;
    bus.in_is_signed = sg;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) begin
      push_word(d, m, sg);
    end else begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each output handshake, checks err timing and stall stability.
  initial begin
    bit         stall_prev = 0;
    logic [7:0] pd;
    logic [1:0] pi;
    logic       pl;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("err", int'(bus.err), int'(err_exp.exists(cyc)));
        if (stall_prev && bus.out_valid) begin
          check("stall_hold", int'({bus.out_data, bus.out_idx, bus.out_last}),
                int'({pd, pi, pl}));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_output", int'(bus.out_data), -1);
          end else begin
            e = sbq.pop_front();
            check("element", int'({bus.out_data, bus.out_idx, bus.out_last}),
                  int'({e.d, e.idx, e.last}));
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        pd = bus.out_data;
        pi = bus.out_idx;
        pl = bus.out_last;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_signed    = '0;
    bus.in_is_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_idx", int'(bus.out_idx), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_err", int'(bus.err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Two 4-bit elements; in_ready reopens on the last element.
    send(8'hD7, 4'b1010, 1'b1);
    @(negedge clk);
    check("in_ready_mid", int'(bus.in_ready), 0);
    @(negedge clk);
    check("in_ready_last", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    drain();

    send(8'hE4, 4'b1111, 1'b1);
    drain();
    send(8'hE4, 4'b1111, 1'b0);
    drain();

    // Back-to-back with no bubble.
    send(8'h9C, 4'b1000, 1'b1);
    send(8'h2F, 4'b1010, 1'b1);
    @(negedge clk);
    check("b2b_first", int'({bus.out_valid, bus.out_data}), int'({1'b1, 8'hFF}));
    @(negedge clk);
    check("b2b_second", int'({bus.out_valid, bus.out_data, bus.out_last}),
          int'({1'b1, 8'h02, 1'b1}));
    @(posedge clk);
    #1;
    drain();

    // Stall for three cycles on the first element.
    rdy_mode = 2;
    send(8'hD7, 4'b1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_elem", int'({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last}),
            int'({1'b1, 8'h07, 2'd0, 1'b0}));
    end
    @(posedge clk);
    #1 rdy_mode = 0;
    drain();

    // Reset while the second element of a 2-bit word is pending.
    send(8'hE4, 4'b1111, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 sbq.delete();
    @(negedge clk);
    check("rst_mid_valid_data", int'({bus.out_valid, bus.out_data}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h5B, 4'b1111, 1'b0);
    @(negedge clk);
    check("after_rst_idx", int'({bus.out_valid, bus.out_idx}), int'({1'b1, 2'd0}));
    @(posedge clk);
    #1;
    drain();

    // Top mask bit clear.
    send(8'hE4, 4'b0101, 1'b1);
    drain();

    rdy_mode = 1;
    for (int w = 0; w < 300; w++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), 4'($urandom), 1'($urandom));
    end
    drain();
    rdy_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
